// File: rtl/seg_display_driver.sv
// seg_display_driver: converts a 14-bit binary value to four BCD digits with a
// sequential double-dabble engine and time-multiplexes them onto a common-anode
// 4-digit 7-segment display with optional blink and leading-zero blanking.
module seg_display_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLINK_DIV = 50000000,
  parameter int LZ_BLANK  = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [13:0] seg_data,
  input  logic [3:0]  dp_mask,
  input  logic        blink_en,
  input  logic        blank,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy
);

  localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LOAD} state_t;

  state_t       state_q;
  logic [13:0]  val_q;
  logic [13:0]  last_q;
  logic [13:0]  bin_q;
  logic [15:0]  bcd_q;
  logic [15:0]  disp_q;
  logic [15:0]  disp_d;
  logic [3:0]   bit_cnt_q;
  logic         pending_q;
  logic         busy_q;
  logic [13:0]  seg_sat;
  logic [15:0]  bcd_adj;

  logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic       dp_q, dp_d;
  logic [3:0] digit;
  logic       lz_off;
  logic       off;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [15:0] bcd_adjust(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int n = 0; n < 4; n++) begin
      if (v[n*4 +: 4] >= 4'd5) r[n*4 +: 4] = v[n*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Active-low gfedcba patterns; non-decimal codes light nothing.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign seg_sat = (seg_data > 14'd9999) ? 14'd9999 : seg_data;
  assign bcd_adj = bcd_adjust(bcd_q);

  // Converter FSM: latch a new value, run 14 shift-add-3 steps, then publish all digits at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      pending_q <= 1'b1;
      busy_q    <= 1'b0;
      val_q     <= '0;
      last_q    <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      disp_q    <= '0;
      bit_cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pending_q || (seg_sat != last_q)) begin
            val_q     <= seg_sat;
            bin_q     <= seg_sat;
            bcd_q     <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[14:0], bin_q, 1'b0};
          bit_cnt_q      <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd13) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          disp_q    <= bcd_q;
          last_q    <= val_q;
          pending_q <= 1'b0;
          busy_q    <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Next-state for scan and blink counters, plus the digit content for the next slot.
  always_comb begin
    disp_d = (state_q == ST_LOAD) ? bcd_q : disp_q;

    scan_cnt_d = scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_cnt_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      idx_d      = idx_q + 2'd1;
    end

    blink_cnt_d = blink_cnt_q + BLINK_W'(1);
    phase_d     = phase_q;
    if (!blink_en) begin
      blink_cnt_d = '0;
      phase_d     = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end

    digit = disp_d[{idx_d, 2'b00} +: 4];
    case (idx_d)
      2'd1:    lz_off = (disp_d[15:4]  == 12'd0);
      2'd2:    lz_off = (disp_d[15:8]  == 8'd0);
      2'd3:    lz_off = (disp_d[15:12] == 4'd0);
      default: lz_off = 1'b0;
    endcase
    lz_off = lz_off && (LZ_BLANK != 0);

    off = blank || (blink_en && !phase_d) || lz_off;

    an_d  = 4'b1111;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!off) begin
      an_d  = ~(4'b0001 << idx_d);
      seg_d = seg_decode(digit);
      dp_d  = ~dp_mask[idx_d];
    end
  end

  // Scan slot and blink phase state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scan_cnt_q  <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      idx_q       <= idx_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // Anode, segment and decimal-point pins registered together so they switch on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      an_q  <= 4'b1111;
      seg_q <= 7'b1111111;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed self-checking bench for seg_display_driver with a fast scan/blink rate.
module tb_seg_display_driver;

  logic        clk;
  logic        reset_n;
  logic [13:0] seg_data;
  logic [3:0]  dp_mask;
  logic        blink_en;
  logic        blank;
  logic [3:0]  an,   an_l;
  logic [6:0]  seg,  seg_l;
  logic        dp,   dp_l;
  logic        busy, busy_l;

  int checks   = 0;
  int failures = 0;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S4 = 7'h19, S5 = 7'h12;
  localparam logic [6:0] S3 = 7'h30, S6 = 7'h02, S7 = 7'h78, S8 = 7'h00, S9 = 7'h10;

  seg_display_driver #(.SCAN_DIV(4), .BLINK_DIV(16), .LZ_BLANK(0)) dut (
    .clk(clk), .reset_n(reset_n), .seg_data(seg_data), .dp_mask(dp_mask),
    .blink_en(blink_en), .blank(blank), .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  seg_display_driver #(.SCAN_DIV(4), .BLINK_DIV(16), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .reset_n(reset_n), .seg_data(seg_data), .dp_mask(dp_mask),
    .blink_en(blink_en), .blank(blank), .an(an_l), .seg(seg_l), .dp(dp_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for a given anode pattern on the plain or LZ instance, then check segments.
  task automatic chk_digit(input string tag, input bit lz, input logic [3:0] pat,
                           input logic [6:0] exp_seg);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if ((lz ? an_l : an) === pat) ok = 1'b1;
    end
    chk({tag, "_found"}, {31'd0, ok}, 32'd1);
    if (ok) chk(tag, {25'd0, (lz ? seg_l : seg)}, {25'd0, exp_seg});
  endtask

  // Wait (bounded) for a conversion to start and finish.
  task automatic wait_conv(input string tag);
    bit seen_hi, done;
    seen_hi = 1'b0;
    done    = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      @(negedge clk);
      if (busy) seen_hi = 1'b1;
      else if (seen_hi) done = 1'b1;
    end
    chk({tag, "_conv_done"}, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int  cnt;
    bit  ok, bad, saw, bad_dp, saw_dp, prev_off, cur_off;
    int  runlen, runs, bad_run;

    reset_n  = 1'b0;
    seg_data = 14'd345;
    dp_mask  = 4'b0000;
    blink_en = 1'b0;
    blank    = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_an",   {28'd0, an},   32'hF);
    chk("rst_seg",  {25'd0, seg},  32'h7F);
    chk("rst_dp",   {31'd0, dp},   32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // First conversion after reset: busy for 14 SHIFT + 1 LOAD cycles
    reset_n = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
    chk("busy_rise", {31'd0, ok}, 32'd1);
    cnt = 0;
    for (int k = 0; k < 40 && busy; k++) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_len", cnt, 32'd15);
    chk_digit("d345_0", 1'b0, 4'b1110, S5);
    chk("d345_0_dp", {31'd0, dp}, 32'd1);
    chk_digit("d345_1", 1'b0, 4'b1101, S4);
    chk_digit("d345_2", 1'b0, 4'b1011, S3);
    chk_digit("d345_3", 1'b0, 4'b0111, S0);

    // Value changes during a conversion in flight
    reset_n = 1'b0;
    @(negedge clk);
    seg_data = 14'd345;
    reset_n  = 1'b1;
    @(negedge clk);
    seg_data = 14'd9999;
    @(negedge clk);
    seg_data = 14'd12;
    saw = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (an !== 4'b1111 && seg === S9) saw = 1'b1;
    end
    chk("no_9999_shown", {31'd0, saw}, 32'd0);
    chk("d12_busy_idle", {31'd0, busy}, 32'd0);
    chk_digit("d12_0", 1'b0, 4'b1110, S2);
    chk_digit("d12_1", 1'b0, 4'b1101, S1);
    chk_digit("d12_2", 1'b0, 4'b1011, S0);
    chk_digit("d12_3", 1'b0, 4'b0111, S0);

    // Saturation: 16383 shows 9999 and does not keep reconverting
    seg_data = 14'd16383;
    wait_conv("sat");
    chk_digit("sat_0", 1'b0, 4'b1110, S9);
    chk_digit("sat_1", 1'b0, 4'b1101, S9);
    chk_digit("sat_2", 1'b0, 4'b1011, S9);
    chk_digit("sat_3", 1'b0, 4'b0111, S9);
    cnt = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    chk("sat_no_reconv", cnt, 32'd0);

    // Leading-zero blanking: 7 lights only the rightmost digit
    seg_data = 14'd7;
    wait_conv("lz7");
    bad = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (an_l !== 4'b1110 && an_l !== 4'b1111) bad = 1'b1;
      if (an_l === 4'b1110) begin
        saw = 1'b1;
        if (seg_l !== S7) bad = 1'b1;
      end
    end
    chk("lz7_only_d0", {31'd0, bad}, 32'd0);
    chk("lz7_d0_seen", {31'd0, saw}, 32'd1);
    chk_digit("nolz7_3", 1'b0, 4'b0111, S0);

    // Leading-zero blanking leaves embedded zeros lit: 1005
    seg_data = 14'd1005;
    wait_conv("lz1005");
    chk_digit("lz1005_0", 1'b1, 4'b1110, S5);
    chk_digit("lz1005_1", 1'b1, 4'b1101, S0);
    chk_digit("lz1005_2", 1'b1, 4'b1011, S0);
    chk_digit("lz1005_3", 1'b1, 4'b0111, S1);

    // Blink with decimal point on digit 2
    dp_mask  = 4'b0100;
    blink_en = 1'b1;
    bad = 1'b0; bad_dp = 1'b0; saw_dp = 1'b0;
    runs = 0; bad_run = 0; runlen = 0;
    prev_off = 1'b0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      cur_off = (an === 4'b1111);
      if (cur_off && (seg !== 7'h7F || dp !== 1'b1)) bad = 1'b1;
      if (!cur_off) begin
        if (dp === 1'b0 && an !== 4'b1011) bad_dp = 1'b1;
        if (an === 4'b1011) begin
          if (dp !== 1'b0) bad_dp = 1'b1;
          else saw_dp = 1'b1;
        end
      end
      if (k > 0 && cur_off != prev_off) begin
        if (runs > 0 && runlen != 16) bad_run++;
        runs++;
        runlen = 1;
      end else begin
        runlen++;
      end
      prev_off = cur_off;
    end
    chk("blink_off_inactive", {31'd0, bad}, 32'd0);
    chk("blink_dp_only_d2", {31'd0, bad_dp}, 32'd0);
    chk("blink_dp_seen", {31'd0, saw_dp}, 32'd1);
    chk("blink_run_len", bad_run, 32'd0);
    chk("blink_runs_ok", {31'd0, (runs >= 5)}, 32'd1);

    // Dropping blink_en during an off phase restores the display next cycle
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (an === 4'b1111) ok = 1'b1;
    end
    chk("blink_off_found", {31'd0, ok}, 32'd1);
    blink_en = 1'b0;
    @(negedge clk);
    chk("blink_drop_on", {31'd0, (an !== 4'b1111)}, 32'd1);

    // Forced blank
    blank = 1'b1;
    @(negedge clk);
    chk("blank_an",  {28'd0, an},  32'hF);
    chk("blank_seg", {25'd0, seg}, 32'h7F);
    chk("blank_dp",  {31'd0, dp},  32'd1);
    blank   = 1'b0;
    dp_mask = 4'b0000;

    // Reset mid-SHIFT is asynchronous and forces a fresh conversion
    seg_data = 14'd2468;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk);
      if (busy) ok = 1'b1;
    end
    chk("mid_busy_rise", {31'd0, ok}, 32'd1);
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("async_an",   {28'd0, an},   32'hF);
    chk("async_seg",  {25'd0, seg},  32'h7F);
    chk("async_dp",   {31'd0, dp},   32'd1);
    chk("async_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("mid_busy_done", {31'd0, busy}, 32'd0);
    chk_digit("d2468_0", 1'b0, 4'b1110, S8);
    chk_digit("d2468_1", 1'b0, 4'b1101, S6);
    chk_digit("d2468_2", 1'b0, 4'b1011, S4);
    chk_digit("d2468_3", 1'b0, 4'b0111, S2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
